// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86-64 pipeline-register bank:
//   - instruction codes (IHALT..IPOPQ), status encodings and RNONE
//   - packed stage-register structs for D, E, M and W
//   - the per-stage BUBBLE (NOP) constants loaded on reset or on bubble
// -----------------------------------------------------------------------------
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Status codes
    localparam logic [1:0] SAOK = 2'd0;
    localparam logic [1:0] SHLT = 2'd1;
    localparam logic [1:0] SADR = 2'd2;
    localparam logic [1:0] SINS = 2'd3;

    // "No register" identifier
    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
    } stage_d_t;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } stage_e_t;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic        Cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } stage_m_t;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } stage_w_t;

    // NOP contents for each stage register
    localparam stage_d_t D_BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0,
                                      rA: RNONE, rB: RNONE,
                                      valC: 64'h0, valP: 64'h0};

    localparam stage_e_t E_BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0,
                                      valC: 64'h0, valA: 64'h0, valB: 64'h0,
                                      dstE: RNONE, dstM: RNONE,
                                      srcA: RNONE, srcB: RNONE};

    localparam stage_m_t M_BUBBLE = '{stat: SAOK, icode: INOP, Cnd: 1'b0,
                                      valE: 64'h0, valA: 64'h0,
                                      dstE: RNONE, dstM: RNONE};

    localparam stage_w_t W_BUBBLE = '{stat: SAOK, icode: INOP,
                                      valE: 64'h0, valM: 64'h0,
                                      dstE: RNONE, dstM: RNONE};

endpackage

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic W-bit pipeline stage register with async active-low reset to BUBBLE.
// Ports:
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset (loads BUBBLE)
//   i_stall   hold current contents (wins over i_bubble)
//   i_bubble  load BUBBLE
//   i_d       next-stage contents
//   o_q       registered contents
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int            W      = 64,
    parameter logic [W-1:0]  BUBBLE = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_stall,
    input  logic         i_bubble,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= BUBBLE;
        end else if (i_stall) begin
            r_q <= r_q;
        end else if (i_bubble) begin
            r_q <= BUBBLE;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/y86_pipe_regs.sv
// -----------------------------------------------------------------------------
// y86_pipe_regs
// Pipeline-register bank for the five-stage Y86-64 core: F, D, E, M, W stage
// registers plus the condition-code register, halt status and counters.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   f_predPC [63:0]     next predicted PC          -> F_predPC
//   d_in  stage_d_t     fetch results  (146 bits)  -> D_out
//   e_in  stage_e_t     decode results (218 bits)  -> E_out
//   m_in  stage_m_t     execute results(143 bits)  -> M_out
//   w_in  stage_w_t     memory results (142 bits)  -> W_out
//   cc_new [2:0]        {ZF,SF,OF} from ALU, written when condition=1 -> cc
//   F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  hazard controls
//   halted              W_out.stat != SAOK
//   retired_cnt         instructions retired (AOK, non-NOP, W not stalled)
//   cycle_cnt           cycles since reset, frozen while halted
// -----------------------------------------------------------------------------
module y86_pipe_regs
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      f_predPC,
    input  stage_d_t         d_in,
    input  stage_e_t         e_in,
    input  stage_m_t         m_in,
    input  stage_w_t         w_in,
    input  logic [2:0]       cc_new,
    input  logic             F_stall,
    input  logic             D_stall,
    input  logic             D_bubble,
    input  logic             E_bubble,
    input  logic             M_bubble,
    input  logic             W_stall,
    input  logic             condition,
    output logic [63:0]      F_predPC,
    output stage_d_t         D_out,
    output stage_e_t         E_out,
    output stage_m_t         M_out,
    output stage_w_t         W_out,
    output logic [2:0]       cc,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int DW = $bits(stage_d_t);
    localparam int EW = $bits(stage_e_t);
    localparam int MW = $bits(stage_m_t);
    localparam int WW = $bits(stage_w_t);

    logic [2:0]       r_cc;
    logic [CNT_W-1:0] r_retired_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic             w_retire;

    // F: stall only
    pipe_stage_reg #(.W(64), .BUBBLE(RESET_PC)) u_f (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_stall  (F_stall),
        .i_bubble (1'b0),
        .i_d      (f_predPC),
        .o_q      (F_predPC)
    );

    // D: stall and bubble
    pipe_stage_reg #(.W(DW), .BUBBLE(D_BUBBLE)) u_d (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_stall  (D_stall),
        .i_bubble (D_bubble),
        .i_d      (d_in),
        .o_q      (D_out)
    );

    // E: bubble only
    pipe_stage_reg #(.W(EW), .BUBBLE(E_BUBBLE)) u_e (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_stall  (1'b0),
        .i_bubble (E_bubble),
        .i_d      (e_in),
        .o_q      (E_out)
    );

    // M: bubble only
    pipe_stage_reg #(.W(MW), .BUBBLE(M_BUBBLE)) u_m (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_stall  (1'b0),
        .i_bubble (M_bubble),
        .i_d      (m_in),
        .o_q      (M_out)
    );

    // W: stall only
    pipe_stage_reg #(.W(WW), .BUBBLE(W_BUBBLE)) u_w (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_stall  (W_stall),
        .i_bubble (1'b0),
        .i_d      (w_in),
        .o_q      (W_out)
    );

    assign halted = (W_out.stat != SAOK);

    // An instruction retires when a real (non-NOP), non-excepting
    // instruction is accepted into W.
    assign w_retire = !W_stall && (w_in.stat == SAOK) && (w_in.icode != INOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc          <= 3'b100;
            r_retired_cnt <= '0;
            r_cycle_cnt   <= '0;
        end else begin
            if (condition) begin
                r_cc <= cc_new;
            end
            if (w_retire) begin
                r_retired_cnt <= r_retired_cnt + CNT_W'(1);
            end
            if (!halted) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
        end
    end

    assign cc          = r_cc;
    assign retired_cnt = r_retired_cnt;
    assign cycle_cnt   = r_cycle_cnt;

endmodule

// File: tb/tb_y86_pipe_regs.sv
module tb_y86_pipe_regs;
    import y86_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [63:0]      f_predPC;
    stage_d_t         d_in;
    stage_e_t         e_in;
    stage_m_t         m_in;
    stage_w_t         w_in;
    logic [2:0]       cc_new;
    logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, condition;
    logic [63:0]      F_predPC;
    stage_d_t         D_out;
    stage_e_t         E_out;
    stage_m_t         M_out;
    stage_w_t         W_out;
    logic [2:0]       cc;
    logic             halted;
    logic [31:0]      retired_cnt;
    logic [31:0]      cycle_cnt;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    y86_pipe_regs #(.RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .f_predPC(f_predPC),
        .d_in(d_in), .e_in(e_in), .m_in(m_in), .w_in(w_in),
        .cc_new(cc_new), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .W_stall(W_stall), .condition(condition),
        .F_predPC(F_predPC), .D_out(D_out), .E_out(E_out), .M_out(M_out),
        .W_out(W_out), .cc(cc), .halted(halted),
        .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected NOP contents, built field by field from the reset rules
    function automatic stage_d_t nop_d();
        stage_d_t s;
        s = '0; s.icode = 4'h1; s.rA = 4'hF; s.rB = 4'hF;
        return s;
    endfunction
    function automatic stage_e_t nop_e();
        stage_e_t s;
        s = '0; s.icode = 4'h1; s.dstE = 4'hF; s.dstM = 4'hF; s.srcA = 4'hF; s.srcB = 4'hF;
        return s;
    endfunction
    function automatic stage_m_t nop_m();
        stage_m_t s;
        s = '0; s.icode = 4'h1; s.dstE = 4'hF; s.dstM = 4'hF;
        return s;
    endfunction
    function automatic stage_w_t nop_w();
        stage_w_t s;
        s = '0; s.icode = 4'h1; s.dstE = 4'hF; s.dstM = 4'hF;
        return s;
    endfunction

    // Behavioural model of what each register must hold
    logic [63:0] mF;
    stage_d_t    mD;
    stage_e_t    mE;
    stage_m_t    mM;
    stage_w_t    mW;
    logic [2:0]  mcc;
    int unsigned mret, mcyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mF = 64'h0; mD = nop_d(); mE = nop_e(); mM = nop_m(); mW = nop_w();
            mcc = 3'b100; mret = 0; mcyc = 0;
        end else begin
            if (mW.stat == 2'd0) mcyc = mcyc + 1;
            if (!W_stall && w_in.stat == 2'd0 && w_in.icode != 4'h1) mret = mret + 1;
            if (!F_stall) mF = f_predPC;
            if (!D_stall) mD = D_bubble ? nop_d() : d_in;
            mE = E_bubble ? nop_e() : e_in;
            mM = M_bubble ? nop_m() : m_in;
            if (!W_stall) mW = w_in;
            if (condition) mcc = cc_new;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("F_predPC", 256'(F_predPC), 256'(mF));
            chk("D_out", 256'(D_out), 256'(mD));
            chk("E_out", 256'(E_out), 256'(mE));
            chk("M_out", 256'(M_out), 256'(mM));
            chk("W_out", 256'(W_out), 256'(mW));
            chk("cc", 256'(cc), 256'(mcc));
            chk("halted", 256'(halted), 256'(mW.stat != 2'd0));
            chk("retired_cnt", 256'(retired_cnt), 256'(mret));
            chk("cycle_cnt", 256'(cycle_cnt), 256'(mcyc));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_ctl();
        F_stall = 0; D_stall = 0; D_bubble = 0; E_bubble = 0;
        M_bubble = 0; W_stall = 0; condition = 0;
    endtask

    task automatic set_data(input int i);
        f_predPC = 64'h1000 + 64'(i) * 64'h8;
        d_in = '0; d_in.icode = 4'(2 + i % 9); d_in.ifun = 4'(i); d_in.rA = 4'(i);
        d_in.rB = 4'(i + 1); d_in.valC = 64'hA5A5_0000 + 64'(i); d_in.valP = 64'h2000 + 64'(i);
        e_in = '0; e_in.icode = 4'(3 + i % 8); e_in.valA = 64'h3000 + 64'(i);
        e_in.valB = 64'(i) * 64'h77; e_in.dstE = 4'h3; e_in.dstM = 4'h5;
        e_in.srcA = 4'h1; e_in.srcB = 4'h2; e_in.valC = 64'hC0DE;
        m_in = '0; m_in.icode = 4'(4 + i % 7); m_in.Cnd = i[0]; m_in.valE = 64'h4000 + 64'(i);
        m_in.valA = 64'hBEEF; m_in.dstE = 4'h6; m_in.dstM = 4'h7;
        w_in = '0; w_in.icode = 4'h6; w_in.valE = 64'h5000 + 64'(i);
        w_in.valM = 64'hF00D; w_in.dstE = 4'h8; w_in.dstM = 4'h9;
    endtask

    stage_m_t mval;

    initial begin
        clr_ctl();
        cc_new = 3'b000;
        set_data(0);
        cyc();
        cyc();
        chk_en = 1'b1;
        rst_n = 1'b1;

        // 1: run, then asynchronous reset between edges
        for (int i = 0; i < 10; i++) begin
            set_data(i);
            condition = i[0];
            cc_new = 3'(i);
            cyc();
        end
        clr_ctl();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst F_predPC", 256'(F_predPC), 256'h0);
        chk("rst D.icode", 256'(D_out.icode), 256'h1);
        chk("rst E.icode", 256'(E_out.icode), 256'h1);
        chk("rst M.icode", 256'(M_out.icode), 256'h1);
        chk("rst W.icode", 256'(W_out.icode), 256'h1);
        chk("rst E.dstE", 256'(E_out.dstE), 256'hF);
        chk("rst W.dstM", 256'(W_out.dstM), 256'hF);
        chk("rst cc", 256'(cc), 256'h4);
        chk("rst retired", 256'(retired_cnt), 256'h0);
        chk("rst cycle", 256'(cycle_cnt), 256'h0);
        chk("rst halted", 256'(halted), 256'h0);
        cyc();
        rst_n = 1'b1;

        // 2: load-use stall
        set_data(20);
        f_predPC = 64'h100; d_in.icode = 4'h6;
        cyc();
        F_stall = 1; D_stall = 1; E_bubble = 1;
        f_predPC = 64'h200; d_in.icode = 4'h3;
        mval = '0; mval.icode = 4'h5; mval.valE = 64'hABC; mval.dstE = 4'h2; mval.dstM = 4'h4;
        m_in = mval;
        cyc();
        chk("lu F_predPC", 256'(F_predPC), 256'h100);
        chk("lu D.icode", 256'(D_out.icode), 256'h6);
        chk("lu E.icode", 256'(E_out.icode), 256'h1);
        chk("lu E.dstE", 256'(E_out.dstE), 256'hF);
        chk("lu E.dstM", 256'(E_out.dstM), 256'hF);
        chk("lu M_out", 256'(M_out), 256'(mval));
        clr_ctl();

        // 3: mispredict
        set_data(30);
        D_bubble = 1; E_bubble = 1;
        d_in.icode = 4'h3; e_in.icode = 4'h2; f_predPC = 64'h300;
        cyc();
        chk("mp D.icode", 256'(D_out.icode), 256'h1);
        chk("mp E.icode", 256'(E_out.icode), 256'h1);
        chk("mp F_predPC", 256'(F_predPC), 256'h300);
        clr_ctl();

        // 4: stall beats bubble
        set_data(40);
        d_in.icode = 4'h4;
        cyc();
        D_stall = 1; D_bubble = 1; d_in.icode = 4'h5;
        cyc();
        chk("sb D.icode", 256'(D_out.icode), 256'h4);
        clr_ctl();

        // 5: condition codes
        condition = 1; cc_new = 3'b010;
        cyc();
        chk("cc write", 256'(cc), 256'h2);
        condition = 0; cc_new = 3'b001;
        cyc();
        chk("cc hold", 256'(cc), 256'h2);

        // 6: retirement counting and halt
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_data(50 + i);
            w_in.icode = (i < 5) ? 4'h6 : 4'h1;
            cyc();
        end
        w_in.stat = 2'd2; w_in.icode = 4'h5;
        cyc();
        W_stall = 1;
        w_in.stat = 2'd0; w_in.icode = 4'h6;
        for (int i = 0; i < 3; i++) cyc();
        chk("h retired", 256'(retired_cnt), 256'd5);
        chk("h halted", 256'(halted), 256'h1);
        chk("h W.stat", 256'(W_out.stat), 256'h2);
        chk("h cycle", 256'(cycle_cnt), 256'd8);
        clr_ctl();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
